// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode constants and class bit indices for the decode queue
package decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int CLS_EXEC     = 0;
  localparam int CLS_LSU      = 1;
  localparam int CLS_BRANCH   = 2;
  localparam int CLS_MUL      = 3;
  localparam int CLS_DIV      = 4;
  localparam int CLS_CSR      = 5;
  localparam int CLS_RD_VALID = 6;
  localparam int CLS_INVALID  = 7;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - combinational RV32IM+Zicsr instruction class decoder
module instr_class_decode
  import decode_pkg::*;
#(
  parameter int SUPPORT_MULDIV = 1
) (
  input  logic [31:0] instr,
  output logic [7:0]  cls
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       writes_rd;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign rd            = instr[11:7];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^instr[24:15];

  // Map the major opcode to a single class bit and note whether rd is written
  always_comb begin
    cls       = '0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == FUNCT7_MULDIV) begin
          if (SUPPORT_MULDIV != 0) begin
            cls[CLS_MUL] = ~funct3[2];
            cls[CLS_DIV] = funct3[2];
            writes_rd    = 1'b1;
          end else begin
            cls[CLS_INVALID] = 1'b1;
          end
        end else begin
          cls[CLS_EXEC] = 1'b1;
          writes_rd     = 1'b1;
        end
      end
      OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
        cls[CLS_EXEC] = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_LOAD: begin
        cls[CLS_LSU] = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_STORE:  cls[CLS_LSU] = 1'b1;
      OPC_BRANCH: cls[CLS_BRANCH] = 1'b1;
      OPC_JAL, OPC_JALR: begin
        cls[CLS_BRANCH] = 1'b1;
        writes_rd       = 1'b1;
      end
      OPC_SYSTEM: begin
        // funct3 == 0 covers ECALL/EBREAK/MRET/WFI, which never write rd
        cls[CLS_CSR] = 1'b1;
        writes_rd    = (funct3 != 3'b000);
      end
      OPC_MISC_MEM: cls[CLS_CSR] = 1'b1;
      default:      cls[CLS_INVALID] = 1'b1;
    endcase
    cls[CLS_RD_VALID] = writes_rd && (rd != 5'd0);
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - splits fetch bundles into an in-order queue and presents decoded head entries
module decode_queue
  import decode_pkg::*;
#(
  parameter int FETCH_WIDTH       = 2,
  parameter int ISSUE_WIDTH       = 2,
  parameter int DEPTH             = 8,
  parameter int SUPPORT_MULDIV    = 1,
  parameter int DECODE_AT_ENQUEUE = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_in_valid_i,
  input  logic [32*FETCH_WIDTH-1:0] fetch_in_instr_i,
  input  logic [FETCH_WIDTH-1:0]   fetch_in_pred_branch_i,
  input  logic                     fetch_in_fault_fetch_i,
  input  logic                     fetch_in_fault_page_i,
  input  logic [31:0]              fetch_in_pc_i,
  output logic                     fetch_in_accept_o,
  output logic [ISSUE_WIDTH-1:0]   fetch_out_valid_o,
  output logic [32*ISSUE_WIDTH-1:0] fetch_out_instr_o,
  output logic [32*ISSUE_WIDTH-1:0] fetch_out_pc_o,
  output logic [ISSUE_WIDTH-1:0]   fetch_out_fault_fetch_o,
  output logic [ISSUE_WIDTH-1:0]   fetch_out_fault_page_o,
  output logic [8*ISSUE_WIDTH-1:0] fetch_out_class_o,
  input  logic [ISSUE_WIDTH-1:0]   fetch_out_accept_i,
  input  logic                     branch_request_i,
  input  logic [31:0]              branch_pc_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] PC_MASK = ~32'(FETCH_WIDTH * 4 - 1);

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic        mem_ff    [DEPTH];
  logic        mem_fp    [DEPTH];

  logic                   fault_any;
  logic                   push;
  logic                   blocked;
  int                     start_idx;
  logic [FETCH_WIDTH-1:0] slot_en;
  logic [CW-1:0]          push_num;
  logic [CW-1:0]          pushed_cnt;
  logic [CW-1:0]          pop_num;
  logic                   pop_run;
  logic [PW-1:0]          wr_idx   [FETCH_WIDTH];
  logic [PW-1:0]          rd_idx   [ISSUE_WIDTH];
  logic [7:0]             head_cls [ISSUE_WIDTH];
  logic                   unused_branch_pc;

  assign unused_branch_pc = ^branch_pc_i;
  assign fault_any  = fetch_in_fault_fetch_i | fetch_in_fault_page_i;
  assign fetch_in_accept_o = ((CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH)) | branch_request_i;
  assign push       = fetch_in_valid_i & fetch_in_accept_o & ~branch_request_i;
  assign pushed_cnt = push ? push_num : '0;

  // Select the contiguous run of slots from the start slot up to a fault or predicted-taken slot
  always_comb begin
    start_idx = int'((fetch_in_pc_i >> 2) & 32'(FETCH_WIDTH - 1));
    slot_en   = '0;
    push_num  = '0;
    blocked   = 1'b0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      wr_idx[j] = tail_q + PW'(j) - PW'(start_idx);
      if (j >= start_idx && !blocked) begin
        slot_en[j] = 1'b1;
        push_num   = push_num + CW'(1);
        if (fault_any || fetch_in_pred_branch_i[j]) blocked = 1'b1;
      end
    end
  end

  // Write enabled slots into consecutive entries starting at the tail
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (slot_en[j]) begin
          mem_instr[wr_idx[j]] <= fault_any ? 32'd0 : fetch_in_instr_i[32*j +: 32];
          mem_pc[wr_idx[j]]    <= (fetch_in_pc_i & PC_MASK) | 32'(j * 4);
          mem_ff[wr_idx[j]]    <= fetch_in_fault_fetch_i;
          mem_fp[wr_idx[j]]    <= fetch_in_fault_page_i;
        end
      end
    end
  end

  generate
    if (DECODE_AT_ENQUEUE != 0) begin : g_enq_decode
      logic [7:0] push_cls [FETCH_WIDTH];
      logic [7:0] mem_cls  [DEPTH];
      for (genvar j = 0; j < FETCH_WIDTH; j++) begin : g_slot
        instr_class_decode #(.SUPPORT_MULDIV(SUPPORT_MULDIV)) u_dec (
          .instr (fetch_in_instr_i[32*j +: 32]),
          .cls   (push_cls[j])
        );
      end
      // Store the class alongside the entry so the head only needs a read
      always_ff @(posedge clk_i) begin
        if (push) begin
          for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (slot_en[j]) mem_cls[wr_idx[j]] <= push_cls[j];
          end
        end
      end
      // Fetch stored classes for the head slots
      always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) head_cls[k] = mem_cls[rd_idx[k]];
      end
    end else begin : g_head_decode
      for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
        instr_class_decode #(.SUPPORT_MULDIV(SUPPORT_MULDIV)) u_dec (
          .instr (mem_instr[rd_idx[k]]),
          .cls   (head_cls[k])
        );
      end
    end
  endgenerate

  // Present head entries, zeroing invalid slots, and count the leading accepted slots
  always_comb begin
    fetch_out_valid_o       = '0;
    fetch_out_instr_o       = '0;
    fetch_out_pc_o          = '0;
    fetch_out_fault_fetch_o = '0;
    fetch_out_fault_page_o  = '0;
    fetch_out_class_o       = '0;
    pop_num                 = '0;
    pop_run                 = 1'b1;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      rd_idx[k] = head_q + PW'(k);
      if (count_q > CW'(k)) begin
        fetch_out_valid_o[k]       = 1'b1;
        fetch_out_instr_o[32*k +: 32] = mem_instr[rd_idx[k]];
        fetch_out_pc_o[32*k +: 32]    = mem_pc[rd_idx[k]];
        fetch_out_fault_fetch_o[k] = mem_ff[rd_idx[k]];
        fetch_out_fault_page_o[k]  = mem_fp[rd_idx[k]];
        // Faulted entries carry no meaningful instruction, so report no class
        if (!(mem_ff[rd_idx[k]] || mem_fp[rd_idx[k]]))
          fetch_out_class_o[8*k +: 8] = head_cls[k];
      end
      pop_run = pop_run & (count_q > CW'(k)) & fetch_out_accept_i[k];
      if (pop_run) pop_num = pop_num + CW'(1);
    end
  end

  // Advance pointers and occupancy; reset beats flush, flush discards push and pop
  always_ff @(posedge clk_i) begin
    if (rst_i || branch_request_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + pop_num[PW-1:0];
      tail_q  <= tail_q + pushed_cnt[PW-1:0];
      count_q <= count_q + pushed_cnt - pop_num;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue against a queue-based reference model
module tb_decode_queue;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int MD    = 1;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [32*FW-1:0] in_instr;
  logic [FW-1:0]   in_pred;
  logic            in_ff;
  logic            in_fp;
  logic [31:0]     in_pc;
  logic            in_accept;
  logic [IW-1:0]   out_valid;
  logic [32*IW-1:0] out_instr;
  logic [32*IW-1:0] out_pc;
  logic [IW-1:0]   out_ff;
  logic [IW-1:0]   out_fp;
  logic [8*IW-1:0] out_class;
  logic [IW-1:0]   out_accept;
  logic            br_req;
  logic [31:0]     br_pc;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ff;
    logic        fp;
  } ent_t;

  ent_t q[$];
  int   total;
  int   bad;

  decode_queue #(
    .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH),
    .SUPPORT_MULDIV(MD), .DECODE_AT_ENQUEUE(0)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .fetch_in_valid_i        (in_valid),
    .fetch_in_instr_i        (in_instr),
    .fetch_in_pred_branch_i  (in_pred),
    .fetch_in_fault_fetch_i  (in_ff),
    .fetch_in_fault_page_i   (in_fp),
    .fetch_in_pc_i           (in_pc),
    .fetch_in_accept_o       (in_accept),
    .fetch_out_valid_o       (out_valid),
    .fetch_out_instr_o       (out_instr),
    .fetch_out_pc_o          (out_pc),
    .fetch_out_fault_fetch_o (out_ff),
    .fetch_out_fault_page_o  (out_fp),
    .fetch_out_class_o       (out_class),
    .fetch_out_accept_i      (out_accept),
    .branch_request_i        (br_req),
    .branch_pc_i             (br_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_class(input logic [31:0] i);
    logic [7:0] c;
    logic rdnz;
    rdnz = (i[11:7] != 5'd0);
    case (i[6:0])
      7'h33: begin
        if (i[31:25] == 7'h01) c = (MD == 0) ? 8'h80 : ((i[14] ? 8'h10 : 8'h08) | (rdnz ? 8'h40 : 8'h00));
        else c = 8'h01 | (rdnz ? 8'h40 : 8'h00);
      end
      7'h13, 7'h37, 7'h17: c = 8'h01 | (rdnz ? 8'h40 : 8'h00);
      7'h03: c = 8'h02 | (rdnz ? 8'h40 : 8'h00);
      7'h23: c = 8'h02;
      7'h63: c = 8'h04;
      7'h6F, 7'h67: c = 8'h04 | (rdnz ? 8'h40 : 8'h00);
      7'h73: c = 8'h20 | ((rdnz && i[14:12] != 3'd0) ? 8'h40 : 8'h00);
      7'h0F: c = 8'h20;
      default: c = 8'h80;
    endcase
    return c;
  endfunction

  task automatic drive(input logic v, input logic [63:0] ins, input logic [1:0] pr,
                       input logic [31:0] pc, input logic f1, input logic f2,
                       input logic [1:0] acc, input logic br);
    in_valid = v; in_instr = ins; in_pred = pr; in_pc = pc;
    in_ff = f1; in_fp = f2; out_accept = acc; br_req = br;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge
  task automatic tick();
    ent_t nq[$];
    ent_t e;
    int pop;
    int s;
    bit acc;
    acc = ((DEPTH - q.size()) >= FW) || br_req;
    pop = 0;
    for (int k = 0; k < IW; k++) begin
      if (k < q.size() && out_accept[k]) pop++;
      else break;
    end
    if (!rst && !br_req) begin
      for (int i = pop; i < q.size(); i++) nq.push_back(q[i]);
      if (in_valid && acc) begin
        s = (in_pc >> 2) % FW;
        for (int j = s; j < FW; j++) begin
          e.pc = (in_pc & ~32'(FW * 4 - 1)) + 32'(j * 4);
          e.ff = in_ff;
          e.fp = in_fp;
          e.instr = (in_ff || in_fp) ? 32'd0 : in_instr[32*j +: 32];
          nq.push_back(e);
          if (in_ff || in_fp || in_pred[j]) break;
        end
      end
    end
    @(posedge clk);
    #1;
    q = nq;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b00, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got %b exp 00", out_valid); end
    total++; if (out_instr !== '0) begin bad++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    total++; if (out_class !== '0) begin bad++; $display("FAIL reset_class got %h exp 0", out_class); end
    total++; if (out_pc !== '0) begin bad++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    total++; if (in_accept !== 1'b1) begin bad++; $display("FAIL reset_accept got %b exp 1", in_accept); end
  endtask

  task automatic test_basic();
    drive(1, {32'h0000A103, 32'h00100093}, 2'b00, 32'h1000, 0, 0, 2'b11, 0);
    tick();
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b11, 0);
    total++; if (out_valid !== 2'b11) begin bad++; $display("FAIL basic_valid got %b exp 11", out_valid); end
    total++; if (out_instr[31:0] !== 32'h00100093) begin bad++; $display("FAIL basic_instr0 got %h exp 00100093", out_instr[31:0]); end
    total++; if (out_instr[63:32] !== 32'h0000A103) begin bad++; $display("FAIL basic_instr1 got %h exp 0000a103", out_instr[63:32]); end
    total++; if (out_pc[31:0] !== 32'h1000) begin bad++; $display("FAIL basic_pc0 got %h exp 1000", out_pc[31:0]); end
    total++; if (out_pc[63:32] !== 32'h1004) begin bad++; $display("FAIL basic_pc1 got %h exp 1004", out_pc[63:32]); end
    total++; if (out_class !== 16'h4241) begin bad++; $display("FAIL basic_class got %h exp 4241", out_class); end
    tick();
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL basic_popped got %b exp 00", out_valid); end
  endtask

  task automatic test_pred();
    drive(1, {32'h00100093, 32'h000000EF}, 2'b01, 32'h1008, 0, 0, 2'b00, 0);
    tick();
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b01, 0);
    total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL pred_valid got %b exp 01", out_valid); end
    total++; if (out_class[7:0] !== 8'h44) begin bad++; $display("FAIL pred_class got %h exp 44", out_class[7:0]); end
    total++; if (out_pc[31:0] !== 32'h1008) begin bad++; $display("FAIL pred_pc got %h exp 1008", out_pc[31:0]); end
    total++; if (out_instr[63:32] !== 32'd0) begin bad++; $display("FAIL pred_slot1_zero got %h exp 0", out_instr[63:32]); end
    tick();
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL pred_drain got %b exp 00", out_valid); end
  endtask

  task automatic test_muldiv();
    drive(1, {32'h022081B3, 32'hFFFFFFFF}, 2'b00, 32'h1014, 0, 0, 2'b00, 0);
    tick();
    total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL mul_valid got %b exp 01", out_valid); end
    total++; if (out_pc[31:0] !== 32'h1014) begin bad++; $display("FAIL mul_pc got %h exp 1014", out_pc[31:0]); end
    total++; if (out_class[7:0] !== ((MD != 0) ? 8'h48 : 8'h80)) begin bad++; $display("FAIL mul_class got %h exp %h", out_class[7:0], (MD != 0) ? 8'h48 : 8'h80); end
    drive(1, {32'h00100093, 32'hFFFFFFFF}, 2'b00, 32'h1018, 0, 0, 2'b01, 0);
    tick();
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b11, 0);
    total++; if (out_valid !== 2'b11) begin bad++; $display("FAIL illegal_valid got %b exp 11", out_valid); end
    total++; if (out_class !== 16'h4180) begin bad++; $display("FAIL illegal_class got %h exp 4180", out_class); end
    total++; if (out_pc[31:0] !== 32'h1018) begin bad++; $display("FAIL illegal_pc got %h exp 1018", out_pc[31:0]); end
    tick();
  endtask

  task automatic test_fault();
    drive(1, {32'h00100093, 32'h00100093}, 2'b00, 32'h1020, 1, 0, 2'b00, 0);
    tick();
    total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL fault_valid got %b exp 01", out_valid); end
    total++; if (out_instr[31:0] !== 32'd0) begin bad++; $display("FAIL fault_instr got %h exp 0", out_instr[31:0]); end
    total++; if (out_ff !== 2'b01 || out_fp !== 2'b00) begin bad++; $display("FAIL fault_flags got ff=%b fp=%b exp ff=01 fp=00", out_ff, out_fp); end
    total++; if (out_class[7:0] !== 8'h00) begin bad++; $display("FAIL fault_class got %h exp 00", out_class[7:0]); end
    drive(1, {32'h00100093, 32'h00100093}, 2'b00, 32'h1024, 0, 1, 2'b01, 0);
    tick();
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b11, 0);
    total++; if (out_valid !== 2'b01 || out_fp !== 2'b01 || out_ff !== 2'b00) begin bad++; $display("FAIL page_fault got v=%b ff=%b fp=%b exp v=01 ff=00 fp=01", out_valid, out_ff, out_fp); end
    total++; if (out_pc[31:0] !== 32'h1024 || out_class[7:0] !== 8'h00) begin bad++; $display("FAIL page_fault_entry got pc=%h cls=%h exp pc=1024 cls=00", out_pc[31:0], out_class[7:0]); end
    tick();
  endtask

  task automatic test_full();
    logic [63:0] b;
    b = {32'h00200113, 32'h00100093};
    drive(1, b, 2'b00, 32'h3000, 0, 0, 2'b00, 0); tick();
    drive(1, b, 2'b00, 32'h3008, 0, 0, 2'b00, 0); tick();
    drive(1, b, 2'b00, 32'h3010, 0, 0, 2'b00, 0); tick();
    total++; if (in_accept !== 1'b1) begin bad++; $display("FAIL full_accept6 got %b exp 1", in_accept); end
    drive(1, b, 2'b00, 32'h301C, 0, 0, 2'b00, 0); tick();
    total++; if (in_accept !== 1'b0) begin bad++; $display("FAIL full_accept7 got %b exp 0", in_accept); end
    total++; if (out_valid !== 2'b11 || out_pc[31:0] !== 32'h3000) begin bad++; $display("FAIL full_head7 got v=%b pc=%h exp v=11 pc=3000", out_valid, out_pc[31:0]); end
    drive(1, b, 2'b00, 32'h3020, 0, 0, 2'b10, 0); tick();
    total++; if (out_pc[31:0] !== 32'h3000 || in_accept !== 1'b0) begin bad++; $display("FAIL gap_accept got pc=%h acc=%b exp pc=3000 acc=0", out_pc[31:0], in_accept); end
    drive(1, b, 2'b00, 32'h3020, 0, 0, 2'b01, 0); tick();
    total++; if (out_pc[31:0] !== 32'h3004 || in_accept !== 1'b1) begin bad++; $display("FAIL pop_only got pc=%h acc=%b exp pc=3004 acc=1", out_pc[31:0], in_accept); end
    drive(1, b, 2'b00, 32'h3020, 0, 0, 2'b00, 0); tick();
    total++; if (in_accept !== 1'b0 || out_pc[31:0] !== 32'h3004) begin bad++; $display("FAIL full8 got pc=%h acc=%b exp pc=3004 acc=0", out_pc[31:0], in_accept); end
    drive(1, b, 2'b00, 32'h3028, 0, 0, 2'b01, 0); tick();
    total++; if (out_pc[31:0] !== 32'h3008 || in_accept !== 1'b0) begin bad++; $display("FAIL pop_at_full got pc=%h acc=%b exp pc=3008 acc=0", out_pc[31:0], in_accept); end
    drive(0, b, 2'b00, 32'h3028, 0, 0, 2'b01, 0); tick();
    drive(1, b, 2'b00, 32'h3028, 0, 0, 2'b01, 0); tick();
    total++; if (out_pc[31:0] !== 32'h3010 || in_accept !== 1'b0) begin bad++; $display("FAIL push_pop got pc=%h acc=%b exp pc=3010 acc=0", out_pc[31:0], in_accept); end
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 8; i++) tick();
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL full_drain got %b exp 00", out_valid); end
  endtask

  task automatic test_flush();
    logic [63:0] b;
    b = {32'h00200113, 32'h00100093};
    drive(1, b, 2'b00, 32'h4000, 0, 0, 2'b00, 0); tick();
    drive(1, b, 2'b00, 32'h4008, 0, 0, 2'b00, 0); tick();
    drive(1, b, 2'b00, 32'h4014, 0, 0, 2'b00, 0); tick();
    drive(1, {32'h30009073, 32'h00100093}, 2'b00, 32'h4020, 0, 0, 2'b11, 1);
    #1;
    total++; if (in_accept !== 1'b1) begin bad++; $display("FAIL flush_accept got %b exp 1", in_accept); end
    tick();
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b00, 0);
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got %b exp 00", out_valid); end
    drive(1, {32'h00100093, 32'h30009073}, 2'b00, 32'h2000, 0, 0, 2'b00, 0); tick();
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b11, 0);
    total++; if (out_valid !== 2'b11 || out_class !== 16'h4120) begin bad++; $display("FAIL refetch_class got v=%b cls=%h exp v=11 cls=4120", out_valid, out_class); end
    total++; if (out_pc[31:0] !== 32'h2000 || out_instr[31:0] !== 32'h30009073) begin bad++; $display("FAIL refetch_entry got pc=%h ins=%h exp pc=2000 ins=30009073", out_pc[31:0], out_instr[31:0]); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [IW-1:0] ev, eff, efp;
    logic [32*IW-1:0] ei, ep;
    logic [8*IW-1:0] ec;
    logic ea;
    logic [63:0] ins;
    pool[0] = 32'h00100093; pool[1] = 32'h0000A103; pool[2] = 32'h000000EF;
    pool[3] = 32'h022081B3; pool[4] = 32'h30009073; pool[5] = 32'h0220C233;
    pool[6] = 32'h00112023; pool[7] = 32'h0000000F;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int j = 0; j < FW; j++)
        ins[32*j +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, ins, 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
            $urandom & 32'hFFFFFFFC, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            2'($urandom), $urandom_range(0, 19) == 0);
      tick();
      rst = 1'b0;
      #1;
      ev = '0; eff = '0; efp = '0; ei = '0; ep = '0; ec = '0;
      for (int k = 0; k < IW; k++) begin
        if (k < q.size()) begin
          ev[k] = 1'b1;
          ei[32*k +: 32] = q[k].instr;
          ep[32*k +: 32] = q[k].pc;
          eff[k] = q[k].ff;
          efp[k] = q[k].fp;
          ec[8*k +: 8] = (q[k].ff || q[k].fp) ? 8'h00 : ref_class(q[k].instr);
        end
      end
      ea = ((DEPTH - q.size()) >= FW) || br_req;
      total++; if (out_valid !== ev) begin bad++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, out_valid, ev); end
      total++; if (out_instr !== ei) begin bad++; $display("FAIL rnd_instr cyc %0d got %h exp %h", cyc, out_instr, ei); end
      total++; if (out_pc !== ep) begin bad++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, out_pc, ep); end
      total++; if (out_ff !== eff || out_fp !== efp) begin bad++; $display("FAIL rnd_fault cyc %0d got %b/%b exp %b/%b", cyc, out_ff, out_fp, eff, efp); end
      total++; if (out_class !== ec) begin bad++; $display("FAIL rnd_class cyc %0d got %h exp %h", cyc, out_class, ec); end
      total++; if (in_accept !== ea) begin bad++; $display("FAIL rnd_accept cyc %0d got %b exp %b", cyc, in_accept, ea); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    br_pc = 32'h0000_8000;
    drive(0, 64'd0, 2'b00, 32'd0, 0, 0, 2'b00, 0);
    test_reset();
    test_basic();
    test_pred();
    test_muldiv();
    test_fault();
    test_full();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
